// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state encoding, stat width and one-hot decode for fifo_wr_arbiter
package fifo_arb_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
  localparam int STAT_W = 32;
  function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) idx |= oh[i] ? 3'(i) : 3'd0;
    return idx;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req above ptr (wrapping)
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);
  logic [PW-1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
  end
  assign vld = |gnt;
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter for the async_fifo write port.
// Define FIFO_WR_ARB_STAT_EN to add per-requester beat/stall and forced-release counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int MAX_PKT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0]         i_req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  input  logic                       i_fifo_full,
  input  logic                       i_fifo_pfull,
  output logic                       o_fifo_wr_en,
  output logic [WIDTH-1:0]           o_fifo_wr_data,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic                       o_busy,
  output logic                       o_err_overlen
`ifdef FIFO_WR_ARB_STAT_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]  o_stat_beats,
  output logic [NUM_REQ*STAT_W-1:0]  o_stat_stall,
  output logic [STAT_W-1:0]          o_stat_ovl
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick_gnt, acc_vec;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, g_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, busy, acc, own_last, forced, pick_vld;
  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req(i_req_valid),
    .ptr(rr_ptr_q),
    .gnt(pick_gnt),
    .vld(pick_vld)
  );
  always_comb begin
    busy = state_q == ST_BUSY;
    g_idx = PW'(onehot2idx(8'(grant_q)));
    o_req_ready = busy && !i_fifo_full ? grant_q : '0;
    acc_vec = o_req_ready & i_req_valid;
    acc = |acc_vec;
    own_last = |(acc_vec & i_req_last);
    forced = acc && !own_last && cnt_q == CNT_W'(MAX_PKT - 1);
    o_fifo_wr_en = acc;
    o_fifo_wr_data = busy ? i_req_data[int'(g_idx)*WIDTH +: WIDTH] : '0;
    err_d = forced;
    state_d = state_q;
    grant_d = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d = cnt_q;
    if (!busy && i_en && !i_fifo_pfull && pick_vld) begin
      state_d = ST_BUSY;
      grant_d = pick_gnt;
    end else if (acc && (own_last || forced)) begin
      state_d = ST_IDLE;
      grant_d = '0;
      rr_ptr_d = g_idx;
      cnt_d = '0;
    end else if (acc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_ptr_q <= PW'(NUM_REQ - 1);
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign o_grant = grant_q;
  assign o_busy = busy;
  assign o_err_overlen = err_q;
`ifdef FIFO_WR_ARB_STAT_EN
  logic [STAT_W-1:0] beats_q [NUM_REQ], beats_d [NUM_REQ];
  logic [STAT_W-1:0] stall_q [NUM_REQ], stall_d [NUM_REQ];
  logic [STAT_W-1:0] ovl_q, ovl_d;
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      beats_d[k] = beats_q[k] + STAT_W'(acc_vec[k]);
      stall_d[k] = stall_q[k] + STAT_W'(i_req_valid[k] & ~acc_vec[k]);
    end
    ovl_d = ovl_q + STAT_W'(forced);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beats_q <= '{default: '0};
      stall_q <= '{default: '0};
      ovl_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
      ovl_q <= ovl_d;
    end
  end
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    assign o_stat_beats[k*STAT_W +: STAT_W] = beats_q[k];
    assign o_stat_stall[k*STAT_W +: STAT_W] = stall_q[k];
  end
  assign o_stat_ovl = ovl_q;
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed packets with a write scoreboard checked by a separate monitor
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, full = 1'b0, pfull = 1'b0;
  logic [N-1:0] valid = '0, last = '0, ready, grant;
  logic [N*W-1:0] data = '0;
  logic wr_en, busy, err;
  logic [W-1:0] wr_data;
  int n_tests = 0, n_fail = 0, n_wr = 0, n_err = 0;
  logic [8:0] rq [N][$];
  logic [11:0] exp_q [$];

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_PKT(16), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_req_valid(valid), .i_req_last(last), .i_req_data(data),
    .o_req_ready(ready), .i_fifo_full(full), .i_fifo_pfull(pfull),
    .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
    .o_grant(grant), .o_busy(busy), .o_err_overlen(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input int k, input int n, input int seq0);
    for (int i = 0; i < n; i++) rq[k].push_back({(i == n - 1), 8'(k*64 + seq0 + i)});
  endtask

  task automatic expect_pkt(input int k, input int n, input int seq0);
    for (int i = 0; i < n; i++) exp_q.push_back({4'(1 << k), 8'(k*64 + seq0 + i)});
  endtask

  function automatic bit all_empty();
    all_empty = exp_q.size() == 0;
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) all_empty = 0;
  endfunction

  task automatic wait_wr(input int target);
    int c = 0;
    while (n_wr < target && c < 200) begin
      @(negedge clk); #2;
      c++;
    end
    chk("wait_wr", 32'(n_wr >= target), 1);
  endtask

  task automatic wait_done();
    int c = 0;
    while (!all_empty() && c < 300) begin
      @(negedge clk); #2;
      c++;
    end
    chk("drain", 32'(all_empty()), 1);
    repeat (3) @(negedge clk);
    #2;
    chk("no_extra", 32'(exp_q.size()), 0);
  endtask

  task automatic rst_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < N; k++) rq[k].delete();
    @(negedge clk); #2;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // requester model: pop beats the DUT accepted, then present the next head
  initial begin
    logic [N-1:0] accm;
    forever begin
      @(negedge clk);
      accm = ready & valid;
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (accm[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        valid[k] = rq[k].size() > 0;
        last[k] = valid[k] ? rq[k][0][8] : 1'b0;
        data[k*W +: W] = valid[k] ? rq[k][0][7:0] : '0;
      end
    end
  end

  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (err) begin
        n_err++;
        chk("err_idle", {27'd0, busy, grant}, 0);
      end
      if (wr_en) begin
        n_wr++;
        chk("wr_not_full", 32'(full), 0);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got data %0h grant %0b expected no write", wr_data, grant);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(wr_data), 32'(e[7:0]));
          chk("wr_grant", 32'(grant), 32'(e[11:8]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int base, e0;
    rst_dut();
    en = 1'b1;
    send(0, 3, 0); send(2, 3, 0);
    expect_pkt(0, 3, 0); expect_pkt(2, 3, 0);
    wait_done();
    rst_dut();
    send(0, 1, 0); send(0, 1, 1); send(1, 1, 0); send(1, 1, 1); send(2, 1, 0); send(3, 1, 0);
    expect_pkt(0, 1, 0); expect_pkt(1, 1, 0); expect_pkt(2, 1, 0);
    expect_pkt(3, 1, 0); expect_pkt(0, 1, 1); expect_pkt(1, 1, 1);
    wait_done();
    rst_dut();
    base = n_wr;
    send(0, 5, 0); expect_pkt(0, 5, 0);
    wait_wr(base + 2);
    @(posedge clk); #1 full = 1'b1;
    repeat (5) begin
      @(negedge clk); #2;
      chk("full_ready", 32'(ready), 0);
      chk("full_wr_en", 32'(wr_en), 0);
      chk("full_grant", 32'(grant), 1);
    end
    @(posedge clk); #1 full = 1'b0;
    wait_done();
    rst_dut();
    base = n_wr;
    send(1, 3, 0); send(2, 2, 0);
    expect_pkt(1, 3, 0); expect_pkt(2, 2, 0);
    wait_wr(base + 1);
    @(posedge clk); #1 pfull = 1'b1;
    wait_wr(base + 3);
    repeat (4) begin
      @(negedge clk); #2;
      chk("pfull_grant", 32'(grant), 0);
      chk("pfull_busy", 32'(busy), 0);
    end
    @(posedge clk); #1 pfull = 1'b0;
    @(negedge clk); #2 chk("pfull_drop_grant", 32'(grant), 0);
    @(negedge clk); #2 chk("pfull_resume_grant", 32'(grant), 32'b0100);
    wait_done();
    rst_dut();
    e0 = n_err;
    send(1, 20, 0); expect_pkt(1, 20, 0);
    wait_done();
    chk("overlen_pulses", 32'(n_err - e0), 1);
    rst_dut();
    base = n_wr;
    send(0, 5, 0); expect_pkt(0, 2, 0);
    wait_wr(base + 1);
    rst_dut();
    send(0, 1, 10); send(2, 1, 10);
    expect_pkt(0, 1, 10); expect_pkt(2, 1, 10);
    wait_done();
    chk("total_overlen", 32'(n_err), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
